// File: rtl/icache_mshr_req_sched.sv
// Icache miss-path downstream request scheduler: per-MSHR fetch state, round-robin
// issue of line reads under an outstanding cap, retirement on returning fill data.
module icache_mshr_req_sched #(
  parameter int unsigned MSHR_ENTRY_NUM  = 8,
  parameter int unsigned ADDR_WIDTH      = 32,
  parameter int unsigned OFFSET_WIDTH    = 6,
  parameter int unsigned TXNID_WIDTH     = 5,
  parameter int unsigned MAX_OUTSTANDING = 4,
  localparam int unsigned IDX_W = (MSHR_ENTRY_NUM > 1) ? $clog2(MSHR_ENTRY_NUM) : 1,
  localparam int unsigned CNT_W = $clog2(MAX_OUTSTANDING + 1)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      alloc_vld,
  input  logic [IDX_W-1:0]          alloc_idx,
  input  logic [ADDR_WIDTH-1:0]     alloc_addr,
  output logic                      alloc_err,
  output logic                      downstream_txreq_vld,
  input  logic                      downstream_txreq_rdy,
  output logic [4:0]                downstream_txreq_opcode,
  output logic [TXNID_WIDTH-1:0]    downstream_txreq_txnid,
  output logic [ADDR_WIDTH-1:0]     downstream_txreq_addr,
  input  logic                      downstream_rxdat_vld,
  input  logic [TXNID_WIDTH-1:0]    downstream_rxdat_txnid,
  output logic                      fill_done_vld,
  output logic [IDX_W-1:0]          fill_done_idx,
  output logic                      rsp_err,
  output logic [MSHR_ENTRY_NUM-1:0] entry_busy,
  output logic [CNT_W-1:0]          outstanding_cnt
);

  localparam logic [4:0]            DOWNSTREAM_OPCODE = 5'd1;
  localparam logic [ADDR_WIDTH-1:0] LINE_MASK = {ADDR_WIDTH{1'b1}} << OFFSET_WIDTH;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_PEND = 2'd1,
    ST_SENT = 2'd2,
    ST_INFL = 2'd3
  } ent_state_e;

  ent_state_e                state_q [MSHR_ENTRY_NUM];
  ent_state_e                state_d [MSHR_ENTRY_NUM];
  logic [ADDR_WIDTH-1:0]     addr_q  [MSHR_ENTRY_NUM];
  logic [ADDR_WIDTH-1:0]     addr_d  [MSHR_ENTRY_NUM];
  logic [MSHR_ENTRY_NUM-1:0] busy_q, busy_d;

  logic                      tx_vld_q, tx_vld_d;
  logic [IDX_W-1:0]          tx_idx_q, tx_idx_d;
  logic [ADDR_WIDTH-1:0]     tx_addr_q, tx_addr_d;
  logic [4:0]                tx_opcode_q, tx_opcode_d;

  logic [IDX_W-1:0]          rr_ptr_q, rr_ptr_d;
  logic [CNT_W-1:0]          cnt_q, cnt_d;

  logic                      alloc_err_q, alloc_err_d;
  logic                      fill_done_vld_q, fill_done_vld_d;
  logic [IDX_W-1:0]          fill_done_idx_q, fill_done_idx_d;
  logic                      rsp_err_q, rsp_err_d;

  logic                      alloc_in_range, alloc_ok;
  logic                      rx_in_range, retire, handshake, load;
  logic [IDX_W-1:0]          rx_idx;
  logic                      pick_found;
  logic [IDX_W-1:0]          pick_idx;
  int unsigned               rr_cand;

  // Event decode, round-robin pick and next-state for every register.
  always_comb begin
    state_d         = state_q;
    addr_d          = addr_q;
    tx_vld_d        = tx_vld_q;
    tx_idx_d        = tx_idx_q;
    tx_addr_d       = tx_addr_q;
    tx_opcode_d     = tx_opcode_q;
    rr_ptr_d        = rr_ptr_q;
    cnt_d           = cnt_q;
    fill_done_idx_d = fill_done_idx_q;
    pick_found      = 1'b0;
    pick_idx        = '0;
    rr_cand         = 0;

    handshake      = tx_vld_q && downstream_txreq_rdy;
    rx_idx         = IDX_W'(downstream_rxdat_txnid);
    rx_in_range    = 32'(downstream_rxdat_txnid) < MSHR_ENTRY_NUM;
    retire         = downstream_rxdat_vld && rx_in_range && (state_q[rx_idx] == ST_INFL);
    alloc_in_range = 32'(alloc_idx) < MSHR_ENTRY_NUM;
    // A same-cycle retire of the target index always beats the alloc.
    alloc_ok       = alloc_vld && alloc_in_range && (state_q[alloc_idx] == ST_IDLE)
                     && !(retire && (rx_idx == alloc_idx));

    for (int unsigned i = 0; i < MSHR_ENTRY_NUM; i++) begin
      rr_cand = (32'(rr_ptr_q) + i) % MSHR_ENTRY_NUM;
      if (!pick_found && (state_q[IDX_W'(rr_cand)] == ST_PEND)) begin
        pick_found = 1'b1;
        pick_idx   = IDX_W'(rr_cand);
      end
    end

    // A retire in this cycle frees a credit for the load on the same edge.
    load = pick_found && (!tx_vld_q || handshake)
           && ((32'(cnt_q) < MAX_OUTSTANDING) || retire);

    if (handshake) begin
      state_d[tx_idx_q] = ST_INFL;
      tx_vld_d          = 1'b0;
    end
    if (retire) begin
      state_d[rx_idx]  = ST_IDLE;
      fill_done_idx_d  = rx_idx;
    end
    if (load) begin
      state_d[pick_idx] = ST_SENT;
      tx_vld_d          = 1'b1;
      tx_idx_d          = pick_idx;
      tx_addr_d         = addr_q[pick_idx] & LINE_MASK;
      tx_opcode_d       = DOWNSTREAM_OPCODE;
      rr_ptr_d          = IDX_W'((32'(pick_idx) + 1) % MSHR_ENTRY_NUM);
    end
    if (alloc_ok) begin
      state_d[alloc_idx] = ST_PEND;
      addr_d[alloc_idx]  = alloc_addr;
    end

    if (load && !retire) begin
      cnt_d = cnt_q + CNT_W'(1);
    end else if (retire && !load) begin
      cnt_d = cnt_q - CNT_W'(1);
    end

    for (int unsigned e = 0; e < MSHR_ENTRY_NUM; e++) begin
      busy_d[IDX_W'(e)] = (state_d[IDX_W'(e)] != ST_IDLE);
    end

    alloc_err_d     = alloc_vld && !alloc_ok;
    fill_done_vld_d = retire;
    rsp_err_d       = downstream_rxdat_vld && !retire;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned e = 0; e < MSHR_ENTRY_NUM; e++) begin
        state_q[IDX_W'(e)] <= ST_IDLE;
        addr_q[IDX_W'(e)]  <= '0;
      end
      busy_q          <= '0;
      tx_vld_q        <= 1'b0;
      tx_idx_q        <= '0;
      tx_addr_q       <= '0;
      tx_opcode_q     <= '0;
      rr_ptr_q        <= '0;
      cnt_q           <= '0;
      alloc_err_q     <= 1'b0;
      fill_done_vld_q <= 1'b0;
      fill_done_idx_q <= '0;
      rsp_err_q       <= 1'b0;
    end else begin
      state_q         <= state_d;
      addr_q          <= addr_d;
      busy_q          <= busy_d;
      tx_vld_q        <= tx_vld_d;
      tx_idx_q        <= tx_idx_d;
      tx_addr_q       <= tx_addr_d;
      tx_opcode_q     <= tx_opcode_d;
      rr_ptr_q        <= rr_ptr_d;
      cnt_q           <= cnt_d;
      alloc_err_q     <= alloc_err_d;
      fill_done_vld_q <= fill_done_vld_d;
      fill_done_idx_q <= fill_done_idx_d;
      rsp_err_q       <= rsp_err_d;
    end
  end

  assign alloc_err               = alloc_err_q;
  assign downstream_txreq_vld    = tx_vld_q;
  assign downstream_txreq_opcode = tx_opcode_q;
  assign downstream_txreq_txnid  = TXNID_WIDTH'(tx_idx_q);
  assign downstream_txreq_addr   = tx_addr_q;
  assign fill_done_vld           = fill_done_vld_q;
  assign fill_done_idx           = fill_done_idx_q;
  assign rsp_err                 = rsp_err_q;
  assign entry_busy              = busy_q;
  assign outstanding_cnt         = cnt_q;

endmodule

// File: tb/tb_icache_mshr_req_sched.sv
// Directed self-checking bench for icache_mshr_req_sched; inputs change 1ns after
// each rising edge and outputs are sampled at that same point.
module tb_icache_mshr_req_sched;

  logic        clk = 1'b0;
  logic        rst;
  logic        alloc_vld;
  logic [2:0]  alloc_idx;
  logic [31:0] alloc_addr;
  logic        alloc_err;
  logic        downstream_txreq_vld;
  logic        downstream_txreq_rdy;
  logic [4:0]  downstream_txreq_opcode;
  logic [4:0]  downstream_txreq_txnid;
  logic [31:0] downstream_txreq_addr;
  logic        downstream_rxdat_vld;
  logic [4:0]  downstream_rxdat_txnid;
  logic        fill_done_vld;
  logic [2:0]  fill_done_idx;
  logic        rsp_err;
  logic [7:0]  entry_busy;
  logic [2:0]  outstanding_cnt;

  int checks   = 0;
  int failures = 0;

  icache_mshr_req_sched dut (
    .clk                     (clk),
    .rst                     (rst),
    .alloc_vld               (alloc_vld),
    .alloc_idx               (alloc_idx),
    .alloc_addr              (alloc_addr),
    .alloc_err               (alloc_err),
    .downstream_txreq_vld    (downstream_txreq_vld),
    .downstream_txreq_rdy    (downstream_txreq_rdy),
    .downstream_txreq_opcode (downstream_txreq_opcode),
    .downstream_txreq_txnid  (downstream_txreq_txnid),
    .downstream_txreq_addr   (downstream_txreq_addr),
    .downstream_rxdat_vld    (downstream_rxdat_vld),
    .downstream_rxdat_txnid  (downstream_rxdat_txnid),
    .fill_done_vld           (fill_done_vld),
    .fill_done_idx           (fill_done_idx),
    .rsp_err                 (rsp_err),
    .entry_busy              (entry_busy),
    .outstanding_cnt         (outstanding_cnt)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst                    = 1'b1;
    alloc_vld              = 1'b0;
    alloc_idx              = '0;
    alloc_addr             = '0;
    downstream_txreq_rdy   = 1'b0;
    downstream_rxdat_vld   = 1'b0;
    downstream_rxdat_txnid = '0;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if ({downstream_txreq_vld, alloc_err, fill_done_vld, rsp_err, entry_busy, outstanding_cnt,
         downstream_txreq_txnid, downstream_txreq_opcode, downstream_txreq_addr, fill_done_idx} !== '0) begin
      failures++;
      $display("FAIL reset_outputs vld=%b aerr=%b fd=%b rerr=%b busy=%h cnt=%0d txnid=%0d op=%0d addr=%h fdidx=%0d required all 0",
               downstream_txreq_vld, alloc_err, fill_done_vld, rsp_err, entry_busy, outstanding_cnt,
               downstream_txreq_txnid, downstream_txreq_opcode, downstream_txreq_addr, fill_done_idx);
    end
    // Hold a request under backpressure, then reset mid-operation.
    alloc_vld = 1'b1; alloc_idx = 3'd6; alloc_addr = 32'h0000_0100;
    tick();
    alloc_vld = 1'b0;
    tick();
    checks++;
    if (downstream_txreq_vld !== 1'b1 || downstream_txreq_txnid !== 5'd6) begin
      failures++;
      $display("FAIL reset_pre_held vld=%b txnid=%0d required vld=1 txnid=6", downstream_txreq_vld, downstream_txreq_txnid);
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++;
    if (downstream_txreq_vld !== 1'b0 || entry_busy !== 8'h00 || outstanding_cnt !== 3'd0) begin
      failures++;
      $display("FAIL reset_mid_op vld=%b busy=%h cnt=%0d required 0 00 0", downstream_txreq_vld, entry_busy, outstanding_cnt);
    end
  endtask

  task automatic test_single_miss();
    do_reset();
    downstream_txreq_rdy = 1'b1;
    alloc_vld = 1'b1; alloc_idx = 3'd3; alloc_addr = 32'h0001_2345;
    tick();
    alloc_vld = 1'b0;
    checks++;
    if (downstream_txreq_vld !== 1'b0 || entry_busy !== 8'h08 || alloc_err !== 1'b0) begin
      failures++;
      $display("FAIL single_t1 vld=%b busy=%h aerr=%b required 0 08 0", downstream_txreq_vld, entry_busy, alloc_err);
    end
    tick();
    checks++;
    if (downstream_txreq_vld !== 1'b1 || downstream_txreq_txnid !== 5'd3 ||
        downstream_txreq_addr !== 32'h0001_2340 || downstream_txreq_opcode !== 5'd1 || outstanding_cnt !== 3'd1) begin
      failures++;
      $display("FAIL single_req vld=%b txnid=%0d addr=%h op=%0d cnt=%0d required 1 3 00012340 1 1",
               downstream_txreq_vld, downstream_txreq_txnid, downstream_txreq_addr, downstream_txreq_opcode, outstanding_cnt);
    end
    tick();
    checks++;
    if (downstream_txreq_vld !== 1'b0 || outstanding_cnt !== 3'd1) begin
      failures++;
      $display("FAIL single_after_hs vld=%b cnt=%0d required 0 1", downstream_txreq_vld, outstanding_cnt);
    end
    downstream_rxdat_vld = 1'b1; downstream_rxdat_txnid = 5'd3;
    tick();
    downstream_rxdat_vld = 1'b0;
    checks++;
    if (fill_done_vld !== 1'b1 || fill_done_idx !== 3'd3 || entry_busy !== 8'h00 ||
        outstanding_cnt !== 3'd0 || rsp_err !== 1'b0) begin
      failures++;
      $display("FAIL single_fill fd=%b idx=%0d busy=%h cnt=%0d rerr=%b required 1 3 00 0 0",
               fill_done_vld, fill_done_idx, entry_busy, outstanding_cnt, rsp_err);
    end
    tick();
    checks++;
    if (fill_done_vld !== 1'b0) begin
      failures++;
      $display("FAIL single_fill_pulse fd=%b required 0", fill_done_vld);
    end
  endtask

  task automatic test_round_robin();
    logic [2:0] alloc_seq [3];
    logic [4:0] exp_txnid [3];
    alloc_seq[0] = 3'd0; alloc_seq[1] = 3'd2; alloc_seq[2] = 3'd5;
    exp_txnid[0] = 5'd0; exp_txnid[1] = 5'd2; exp_txnid[2] = 5'd5;
    do_reset();
    downstream_txreq_rdy = 1'b1;
    for (int i = 0; i < 4; i++) begin
      alloc_vld  = (i < 3);
      alloc_idx  = (i < 3) ? alloc_seq[i] : 3'd0;
      alloc_addr = 32'h0000_1000;
      tick();
      if (i > 0) begin
        checks++;
        if (downstream_txreq_vld !== 1'b1 || downstream_txreq_txnid !== exp_txnid[i-1]) begin
          failures++;
          $display("FAIL rr_first_order step=%0d vld=%b txnid=%0d required 1 %0d",
                   i, downstream_txreq_vld, downstream_txreq_txnid, exp_txnid[i-1]);
        end
      end
    end
    checks++;
    if (outstanding_cnt !== 3'd3) begin
      failures++;
      $display("FAIL rr_cnt3 cnt=%0d required 3", outstanding_cnt);
    end
    // Stall entry 5 while retiring 0 and 2 and allocating 1 then 6.
    downstream_txreq_rdy = 1'b0;
    downstream_rxdat_vld = 1'b1; downstream_rxdat_txnid = 5'd0;
    alloc_vld = 1'b1; alloc_idx = 3'd1;
    tick();
    downstream_rxdat_txnid = 5'd2;
    alloc_idx = 3'd6;
    tick();
    downstream_rxdat_vld = 1'b0;
    alloc_vld = 1'b0;
    checks++;
    if (fill_done_vld !== 1'b1 || fill_done_idx !== 3'd2 || outstanding_cnt !== 3'd1 ||
        downstream_txreq_txnid !== 5'd5 || entry_busy !== 8'h62) begin
      failures++;
      $display("FAIL rr_stall fd=%b idx=%0d cnt=%0d txnid=%0d busy=%h required 1 2 1 5 62",
               fill_done_vld, fill_done_idx, outstanding_cnt, downstream_txreq_txnid, entry_busy);
    end
    downstream_txreq_rdy = 1'b1;
    tick();
    checks++;
    if (downstream_txreq_vld !== 1'b1 || downstream_txreq_txnid !== 5'd6) begin
      failures++;
      $display("FAIL rr_wrap_first vld=%b txnid=%0d required 1 6", downstream_txreq_vld, downstream_txreq_txnid);
    end
    tick();
    checks++;
    if (downstream_txreq_vld !== 1'b1 || downstream_txreq_txnid !== 5'd1 || outstanding_cnt !== 3'd3) begin
      failures++;
      $display("FAIL rr_wrap_second vld=%b txnid=%0d cnt=%0d required 1 1 3",
               downstream_txreq_vld, downstream_txreq_txnid, outstanding_cnt);
    end
    tick();
    checks++;
    if (downstream_txreq_vld !== 1'b0) begin
      failures++;
      $display("FAIL rr_drain vld=%b required 0", downstream_txreq_vld);
    end
  endtask

  task automatic test_credit_cap();
    do_reset();
    downstream_txreq_rdy = 1'b1;
    for (int i = 0; i < 8; i++) begin
      alloc_vld  = 1'b1;
      alloc_idx  = 3'(i);
      alloc_addr = 32'h0004_0000 + 32'(i * 64);
      tick();
      checks++;
      if (downstream_txreq_vld !== ((i >= 1) && (i <= 4)) ||
          ((i >= 1) && (i <= 4) && downstream_txreq_txnid !== 5'(i - 1))) begin
        failures++;
        $display("FAIL cap_issue step=%0d vld=%b txnid=%0d required vld=%b txnid=%0d",
                 i, downstream_txreq_vld, downstream_txreq_txnid, (i >= 1) && (i <= 4), i - 1);
      end
    end
    alloc_vld = 1'b0;
    tick();
    checks++;
    if (downstream_txreq_vld !== 1'b0 || outstanding_cnt !== 3'd4 || entry_busy !== 8'hFF) begin
      failures++;
      $display("FAIL cap_full vld=%b cnt=%0d busy=%h required 0 4 FF", downstream_txreq_vld, outstanding_cnt, entry_busy);
    end
    downstream_rxdat_vld = 1'b1; downstream_rxdat_txnid = 5'd1;
    tick();
    downstream_rxdat_vld = 1'b0;
    checks++;
    if (fill_done_vld !== 1'b1 || fill_done_idx !== 3'd1 || downstream_txreq_vld !== 1'b1 ||
        downstream_txreq_txnid !== 5'd4 || downstream_txreq_addr !== 32'h0004_0100 || outstanding_cnt !== 3'd4) begin
      failures++;
      $display("FAIL cap_refill fd=%b idx=%0d vld=%b txnid=%0d addr=%h cnt=%0d required 1 1 1 4 00040100 4",
               fill_done_vld, fill_done_idx, downstream_txreq_vld, downstream_txreq_txnid, downstream_txreq_addr, outstanding_cnt);
    end
    tick();
    checks++;
    if (downstream_txreq_vld !== 1'b0 || outstanding_cnt !== 3'd4) begin
      failures++;
      $display("FAIL cap_refull vld=%b cnt=%0d required 0 4", downstream_txreq_vld, outstanding_cnt);
    end
  endtask

  task automatic test_backpressure();
    do_reset();
    alloc_vld = 1'b1; alloc_idx = 3'd3; alloc_addr = 32'hABCD_EF7F;
    tick();
    alloc_idx = 3'd4; alloc_addr = 32'h0000_1040;
    tick();
    alloc_vld = 1'b0;
    for (int i = 0; i < 5; i++) begin
      // First stalled cycle also probes a response for a SENT (not INFL) entry.
      downstream_rxdat_vld = (i == 0); downstream_rxdat_txnid = 5'd3;
      tick();
      checks++;
      if (downstream_txreq_vld !== 1'b1 || downstream_txreq_txnid !== 5'd3 ||
          downstream_txreq_addr !== 32'hABCD_EF40 || downstream_txreq_opcode !== 5'd1 || outstanding_cnt !== 3'd1) begin
        failures++;
        $display("FAIL bp_hold cyc=%0d vld=%b txnid=%0d addr=%h op=%0d cnt=%0d required 1 3 ABCDEF40 1 1",
                 i, downstream_txreq_vld, downstream_txreq_txnid, downstream_txreq_addr, downstream_txreq_opcode, outstanding_cnt);
      end
      if (i == 0) begin
        checks++;
        if (rsp_err !== 1'b1 || fill_done_vld !== 1'b0) begin
          failures++;
          $display("FAIL bp_rsp_sent rerr=%b fd=%b required 1 0", rsp_err, fill_done_vld);
        end
      end
    end
    downstream_rxdat_vld = 1'b0;
    downstream_txreq_rdy = 1'b1;
    tick();
    checks++;
    if (downstream_txreq_vld !== 1'b1 || downstream_txreq_txnid !== 5'd4 || downstream_txreq_addr !== 32'h0000_1040) begin
      failures++;
      $display("FAIL bp_next vld=%b txnid=%0d addr=%h required 1 4 00001040",
               downstream_txreq_vld, downstream_txreq_txnid, downstream_txreq_addr);
    end
    tick();
    checks++;
    if (downstream_txreq_vld !== 1'b0 || outstanding_cnt !== 3'd2) begin
      failures++;
      $display("FAIL bp_done vld=%b cnt=%0d required 0 2", downstream_txreq_vld, outstanding_cnt);
    end
  endtask

  task automatic test_errors();
    do_reset();
    downstream_txreq_rdy = 1'b1;
    alloc_vld = 1'b1; alloc_idx = 3'd2; alloc_addr = 32'h0000_2000;
    tick();
    alloc_vld = 1'b0;
    tick();
    tick();
    alloc_vld = 1'b1; alloc_idx = 3'd2; alloc_addr = 32'hFFFF_FFC0;
    tick();
    alloc_vld = 1'b0;
    checks++;
    if (alloc_err !== 1'b1 || entry_busy !== 8'h04 || outstanding_cnt !== 3'd1 || downstream_txreq_vld !== 1'b0) begin
      failures++;
      $display("FAIL err_alloc_infl aerr=%b busy=%h cnt=%0d vld=%b required 1 04 1 0",
               alloc_err, entry_busy, outstanding_cnt, downstream_txreq_vld);
    end
    downstream_rxdat_vld = 1'b1; downstream_rxdat_txnid = 5'd7;
    tick();
    checks++;
    if (alloc_err !== 1'b0 || rsp_err !== 1'b1 || fill_done_vld !== 1'b0 ||
        outstanding_cnt !== 3'd1 || downstream_txreq_vld !== 1'b0 || entry_busy !== 8'h04) begin
      failures++;
      $display("FAIL err_rsp_idle aerr=%b rerr=%b fd=%b cnt=%0d vld=%b busy=%h required 0 1 0 1 0 04",
               alloc_err, rsp_err, fill_done_vld, outstanding_cnt, downstream_txreq_vld, entry_busy);
    end
    downstream_rxdat_txnid = 5'd20;
    tick();
    checks++;
    if (rsp_err !== 1'b1 || outstanding_cnt !== 3'd1) begin
      failures++;
      $display("FAIL err_rsp_range rerr=%b cnt=%0d required 1 1", rsp_err, outstanding_cnt);
    end
    downstream_rxdat_txnid = 5'd2;
    tick();
    downstream_rxdat_vld = 1'b0;
    checks++;
    if (rsp_err !== 1'b0 || fill_done_vld !== 1'b1 || fill_done_idx !== 3'd2 ||
        outstanding_cnt !== 3'd0 || entry_busy !== 8'h00) begin
      failures++;
      $display("FAIL err_recover rerr=%b fd=%b idx=%0d cnt=%0d busy=%h required 0 1 2 0 00",
               rsp_err, fill_done_vld, fill_done_idx, outstanding_cnt, entry_busy);
    end
  endtask

  task automatic test_simultaneous();
    do_reset();
    downstream_txreq_rdy = 1'b1;
    alloc_vld = 1'b1; alloc_idx = 3'd4; alloc_addr = 32'h0000_4000;
    tick();
    alloc_vld = 1'b0;
    tick();
    tick();
    downstream_rxdat_vld = 1'b1; downstream_rxdat_txnid = 5'd4;
    alloc_vld = 1'b1; alloc_idx = 3'd4; alloc_addr = 32'h0000_5000;
    tick();
    downstream_rxdat_vld = 1'b0;
    checks++;
    if (fill_done_vld !== 1'b1 || fill_done_idx !== 3'd4 || alloc_err !== 1'b1 || entry_busy !== 8'h00) begin
      failures++;
      $display("FAIL sim_retire_wins fd=%b idx=%0d aerr=%b busy=%h required 1 4 1 00",
               fill_done_vld, fill_done_idx, alloc_err, entry_busy);
    end
    tick();
    alloc_vld = 1'b0;
    checks++;
    if (alloc_err !== 1'b0 || entry_busy !== 8'h10) begin
      failures++;
      $display("FAIL sim_realloc aerr=%b busy=%h required 0 10", alloc_err, entry_busy);
    end
    tick();
    checks++;
    if (downstream_txreq_vld !== 1'b1 || downstream_txreq_txnid !== 5'd4 || downstream_txreq_addr !== 32'h0000_5000) begin
      failures++;
      $display("FAIL sim_reissue vld=%b txnid=%0d addr=%h required 1 4 00005000",
               downstream_txreq_vld, downstream_txreq_txnid, downstream_txreq_addr);
    end
  endtask

  initial begin
    test_reset();
    test_single_miss();
    test_round_robin();
    test_credit_cap();
    test_backpressure();
    test_errors();
    test_simultaneous();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
